// File: rtl/ex7_slice_sched.sv
// Round-robin scheduler sharing one pipelined ex7 slice among N_REQ requesters; one op in flight, SLICE_LAT+3 cycles best case.
// Response held until rsp_ready; no grants while busy. EX7_SCHED_CHAIN_EN adds req_chain and per-requester carry feedback into slice_x[7].
module ex7_slice_sched #(
  parameter int  N_REQ     = 4,
  parameter int  SLICE_LAT = 2,
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [16*N_REQ-1:0]  req_x,
`ifdef EX7_SCHED_CHAIN_EN
  input  logic [N_REQ-1:0]     req_chain,
`endif
  output logic [15:0]          slice_x,
  output logic                 slice_issue,
  input  logic [4:0]           slice_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4:0]           rsp_y,
  output logic [ID_W-1:0]      rsp_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_idx;
  logic [ID_W-1:0]   r_rsp_id;
  logic [15:0]       r_slice_x;
  logic              r_issue;
  logic              r_rsp_vld;
  logic [4:0]        r_rsp_y;
  logic [3:0]        r_cnt;

  logic              w_any;
  logic [ID_W-1:0]   w_gnt;
  int                w_pos;
  logic [N_REQ-1:0]  w_ready;
  logic [15:0]       w_x_raw;
  logic [15:0]       w_x_sel;

  // First valid requester at or above the pointer, wrapping at N_REQ-1.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_pos = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = int'(r_ptr) + k;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_any && (w_pos == i) && req_valid[i]) begin
          w_any = 1'b1;
          w_gnt = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_ready = '0;
    w_x_raw = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_ready[i] = (r_state == S_IDLE) && w_any && rst_n;
        w_x_raw    = req_x[16*i +: 16];
      end
    end
  end

`ifdef EX7_SCHED_CHAIN_EN
  logic [N_REQ-1:0] r_cq;

  always_comb begin
    w_x_sel = w_x_raw;
    for (int i = 0; i < N_REQ; i++) begin
      if ((w_gnt == ID_W'(i)) && req_chain[i]) w_x_sel[7] = r_cq[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cq <= '0;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (r_rsp_id == ID_W'(i)) r_cq[i] <= r_rsp_y[4];
      end
    end
  end
`else
  always_comb w_x_sel = w_x_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_rsp_id  <= '0;
      r_slice_x <= '0;
      r_issue   <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp_y   <= '0;
      r_cnt     <= '0;
    end else begin
      r_issue <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_slice_x <= w_x_sel;
            r_idx     <= w_gnt;
            r_ptr     <= (w_gnt == ID_W'(N_REQ-1)) ? '0 : w_gnt + 1'b1;
            r_issue   <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= 4'(SLICE_LAT-1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rsp_y   <= slice_y;
            r_rsp_id  <= r_idx;
            r_rsp_vld <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = w_ready;
  assign slice_x     = r_slice_x;
  assign slice_issue = r_issue;
  assign rsp_valid   = r_rsp_vld;
  assign rsp_y       = r_rsp_y;
  assign rsp_id      = r_rsp_id;

endmodule

// File: tb/tb_ex7_slice_sched.sv
// Directed bench for ex7_slice_sched: 4-requester and 3-requester instances, popcount stands in for the ex7 slice.
module tb_ex7_slice_sched;
  localparam int LAT = 2;

  logic clk;
  logic rst_n;

  logic [3:0]   a_req_valid, a_req_ready, a_req_chain;
  logic [63:0]  a_req_x;
  logic [15:0]  a_slice_x;
  logic         a_slice_issue, a_rsp_valid, a_rsp_ready;
  logic [4:0]   a_slice_y, a_rsp_y;
  logic [1:0]   a_rsp_id;

  logic [2:0]   b_req_valid, b_req_ready, b_req_chain;
  logic [47:0]  b_req_x;
  logic [15:0]  b_slice_x;
  logic         b_slice_issue, b_rsp_valid, b_rsp_ready;
  logic [4:0]   b_slice_y, b_rsp_y;
  logic [1:0]   b_rsp_id;

  int n_chk  = 0;
  int n_fail = 0;

  ex7_slice_sched #(.N_REQ(4), .SLICE_LAT(LAT)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_x(a_req_x),
`ifdef EX7_SCHED_CHAIN_EN
    .req_chain(a_req_chain),
`endif
    .slice_x(a_slice_x), .slice_issue(a_slice_issue), .slice_y(a_slice_y),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_y(a_rsp_y), .rsp_id(a_rsp_id)
  );

  ex7_slice_sched #(.N_REQ(3), .SLICE_LAT(LAT)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_x(b_req_x),
`ifdef EX7_SCHED_CHAIN_EN
    .req_chain(b_req_chain),
`endif
    .slice_x(b_slice_x), .slice_issue(b_slice_issue), .slice_y(b_slice_y),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_y(b_rsp_y), .rsp_id(b_rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ex7_model(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  // Golden slice followed by a LAT-stage delay line, one per instance.
  logic [4:0] a_pipe [LAT];
  logic [4:0] b_pipe [LAT];
  always @(posedge clk) begin
    a_pipe[0] <= ex7_model(a_slice_x);
    b_pipe[0] <= ex7_model(b_slice_x);
    for (int i = 1; i < LAT; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
  end
  assign a_slice_y = a_pipe[LAT-1];
  assign b_slice_y = b_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete A operation with rsp_ready=1; entered and left one step after a rising edge, in IDLE.
  task automatic a_op(input int id, input logic [15:0] sx, input logic [4:0] y);
    #1;
    chk("a_gnt", {28'd0, a_req_ready}, 32'd1 << id);
    tick;
    chk("a_issue", {31'd0, a_slice_issue}, 32'd1);
    chk("a_slice_x", {16'd0, a_slice_x}, {16'd0, sx});
    chk("a_rdy_busy", {28'd0, a_req_ready}, 32'd0);
    tick;
    chk("a_issue_once", {31'd0, a_slice_issue}, 32'd0);
    tick;
    chk("a_rsp_early", {31'd0, a_rsp_valid}, 32'd0);
    tick;
    chk("a_rsp_vld", {31'd0, a_rsp_valid}, 32'd1);
    chk("a_rsp_y", {27'd0, a_rsp_y}, {27'd0, y});
    chk("a_rsp_id", {30'd0, a_rsp_id}, id);
    tick;
    chk("a_rsp_clr", {31'd0, a_rsp_valid}, 32'd0);
  endtask

  task automatic b_op(input int id, input logic [4:0] y);
    #1;
    chk("b_gnt", {29'd0, b_req_ready}, 32'd1 << id);
    repeat (LAT + 2) tick;
    chk("b_rsp_vld", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_rsp_y", {27'd0, b_rsp_y}, {27'd0, y});
    chk("b_rsp_id", {30'd0, b_rsp_id}, id);
    tick;
  endtask

  initial begin
    rst_n       = 1'b0;
    a_req_valid = 4'b1111;
    a_req_x     = '0;
    a_req_chain = '0;
    a_rsp_ready = 1'b0;
    b_req_valid = '0;
    b_req_x     = '0;
    b_req_chain = '0;
    b_rsp_ready = 1'b1;
    repeat (3) tick;
    chk("rst_rdy", {28'd0, a_req_ready}, 32'd0);
    chk("rst_issue", {31'd0, a_slice_issue}, 32'd0);
    chk("rst_vld", {31'd0, a_rsp_valid}, 32'd0);
    a_req_valid = '0;
    rst_n = 1'b1;
    tick;

    // Single request on port 2, operand zero
    a_req_x     = {16'h7000, 16'h0000, 16'h00FF, 16'h0001};
    a_req_valid = 4'b0100;
    #1;
    chk("t2_gnt", {28'd0, a_req_ready}, 32'h4);
    tick;
    a_req_valid = '0;
    chk("t2_issue", {31'd0, a_slice_issue}, 32'd1);
    tick;
    chk("t2_issue_lo", {31'd0, a_slice_issue}, 32'd0);
    chk("t2_vld_t2", {31'd0, a_rsp_valid}, 32'd0);
    tick;
    chk("t2_vld_t3", {31'd0, a_rsp_valid}, 32'd0);
    tick;
    chk("t2_vld_t4", {31'd0, a_rsp_valid}, 32'd1);
    chk("t2_y", {27'd0, a_rsp_y}, 32'd0);
    chk("t2_id", {30'd0, a_rsp_id}, 32'd2);

    // Consumer stall with every requester pending
    a_req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("stall_vld", {31'd0, a_rsp_valid}, 32'd1);
      chk("stall_id", {30'd0, a_rsp_id}, 32'd2);
      chk("stall_rdy", {28'd0, a_req_ready}, 32'd0);
      chk("stall_issue", {31'd0, a_slice_issue}, 32'd0);
    end
    a_rsp_ready = 1'b1;
    tick;
    chk("release_vld", {31'd0, a_rsp_valid}, 32'd0);
    a_op(3, 16'h7000, 5'd3);

    // Reset in the middle of WAIT for requester 1
    a_req_valid = 4'b0010;
    #1;
    chk("t1_gnt", {28'd0, a_req_ready}, 32'h2);
    tick;
    tick;
    rst_n = 1'b0;
    a_req_valid = 4'b1111;
    a_req_x     = {16'h7000, 16'hFFFF, 16'h00FF, 16'h0001};
    #1;
    chk("t1_rdy", {28'd0, a_req_ready}, 32'd0);
    chk("t1_slice_x", {16'd0, a_slice_x}, 32'd0);
    chk("t1_issue", {31'd0, a_slice_issue}, 32'd0);
    chk("t1_vld", {31'd0, a_rsp_valid}, 32'd0);
    chk("t1_y", {27'd0, a_rsp_y}, 32'd0);
    chk("t1_id", {30'd0, a_rsp_id}, 32'd0);
    tick;
    rst_n = 1'b1;

    // All four pending: round-robin from 0 after reset
    a_op(0, 16'h0001, 5'd1);
    a_op(1, 16'h00FF, 5'd8);
    a_op(2, 16'hFFFF, 5'd16);
    a_op(3, 16'h7000, 5'd3);
    a_req_x[15:0] = 16'h1234;
    a_op(0, 16'h1234, 5'd5);

`ifdef EX7_SCHED_CHAIN_EN
    a_req_valid   = 4'b0001;
    a_req_x[15:0] = 16'hFFFF;
    a_op(0, 16'hFFFF, 5'd16);
    a_req_chain   = 4'b0001;
    a_req_x[15:0] = 16'h0000;
    a_op(0, 16'h0080, 5'd1);
    a_req_chain   = '0;
`endif
    a_req_valid = '0;

    // Three requesters: pointer wraps from 2 straight to 0
    b_req_x     = {16'h0007, 16'h000F, 16'h0003};
    b_req_valid = 3'b100;
    b_op(2, 5'd3);
    b_req_valid = 3'b111;
    b_op(0, 5'd2);
    b_op(1, 5'd4);
    b_op(2, 5'd3);
    b_req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
